// File: rtl/ts_bin_mapper.sv
// Timestamp-to-bin mapper feeding the histogram builder: alternates coarse (CH)
// and fine (FH) passes, each framed to exactly FRAME_EVENTS emitted bin writes.
module ts_bin_mapper #(
  parameter int unsigned NB           = 5,
  parameter int unsigned CH_SHIFT     = 11,
  parameter int unsigned FH_SHIFT     = 6,
  parameter int unsigned FRAME_EVENTS = 13333200,
  parameter int unsigned EVT_W        = 24,
  localparam int unsigned TS_W        = CH_SHIFT + NB
) (
  input  logic            clk,
  input  logic            res,
  input  logic            en,
  input  logic            ts_valid,
  input  logic [TS_W-1:0] ts_data,
  output logic            ts_ready,
  input  logic [NB-1:0]   peak_ch,
  input  logic            peak_done,
  output logic            wrEn,
  output logic [NB-1:0]   addr,
  output logic            mode,
  output logic            frame_done,
  output logic [15:0]     drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CH_RUN,
    S_PEAK_WAIT,
    S_FH_RUN
  } state_e;

  localparam logic [EVT_W-1:0] FRAME_LAST = EVT_W'(FRAME_EVENTS);

  state_e            state_q, state_d;
  logic [EVT_W-1:0]  evt_cnt_q, evt_cnt_d;
  logic [TS_W-1:0]   base_q, base_d;
  logic              mode_q, mode_d;
  logic              wr_en_q, wr_en_d;
  logic [NB-1:0]     addr_q, addr_d;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic              running;
  logic              frame_full;
  logic              accept;
  logic              in_window;
  logic [NB-1:0]     coarse_addr;
  logic [NB-1:0]     fine_addr;

  assign running     = (state_q == S_CH_RUN) || (state_q == S_FH_RUN);
  assign frame_full  = (evt_cnt_q == FRAME_LAST);
  assign ts_ready    = running && (evt_cnt_q < FRAME_LAST);
  assign accept      = ts_valid && ts_ready;
  assign coarse_addr = ts_data[TS_W-1:CH_SHIFT];
  assign in_window   = (coarse_addr == base_q[TS_W-1:CH_SHIFT]);
  // base has zero low bits, so the in-window offset always fits NB bits.
  assign fine_addr   = NB'((ts_data - base_q) >> FH_SHIFT);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d      = state_q;
    evt_cnt_d    = evt_cnt_q;
    base_d       = base_q;
    mode_d       = mode_q;
    addr_d       = addr_q;
    drop_cnt_d   = drop_cnt_q;
    wr_en_d      = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_CH_RUN;
      end
      S_CH_RUN: begin
        if (frame_full) begin
          state_d   = S_PEAK_WAIT;
          evt_cnt_d = '0;
        end else if (accept) begin
          wr_en_d   = 1'b1;
          addr_d    = coarse_addr;
          evt_cnt_d = evt_cnt_q + EVT_W'(1);
        end
      end
      S_PEAK_WAIT: begin
        if (peak_done) begin
          state_d   = S_FH_RUN;
          base_d    = {peak_ch, {CH_SHIFT{1'b0}}};
          mode_d    = 1'b1;
          evt_cnt_d = '0;
        end
      end
      S_FH_RUN: begin
        if (frame_full) begin
          state_d      = en ? S_CH_RUN : S_IDLE;
          evt_cnt_d    = '0;
          mode_d       = 1'b0;
          frame_done_d = 1'b1;
        end else if (accept) begin
          if (in_window) begin
            wr_en_d   = 1'b1;
            addr_d    = fine_addr;
            evt_cnt_d = evt_cnt_q + EVT_W'(1);
          end else if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q      <= S_IDLE;
      evt_cnt_q    <= '0;
      base_q       <= '0;
      mode_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      evt_cnt_q    <= evt_cnt_d;
      base_q       <= base_d;
      mode_q       <= mode_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign wrEn       = wr_en_q;
  assign addr       = addr_q;
  assign mode       = mode_q;
  assign frame_done = frame_done_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: doc/ts_bin_mapper.md
Name: ts_bin_mapper

Overview:
- Upstream feeder for the histogram builder: turns raw TDC timestamps into bin write strobes (wrEn/addr).
- Runs alternating passes: a coarse-histogram (CH) pass, then a fine-histogram (FH) pass zoomed onto the coarse peak bin the builder reports.
- Frames each pass to exactly FRAME_EVENTS emitted writes, so the builder's input/pixel/acquisition counters stay aligned.

Parameters:
- NB, 5, bin address width (matches builder `Nb).
- CH_SHIFT, 11, right shift giving the coarse bin; TS_W = CH_SHIFT+NB.
- FH_SHIFT, 6, right shift giving the fine bin; CH_SHIFT-FH_SHIFT must equal NB.
- FRAME_EVENTS, 13333200, emitted writes per pass (DATA_NUM*PIXEL_NUM*ACQ_NUM = 2*200*33333).
- EVT_W, 24, event counter width; must hold FRAME_EVENTS.

Ports:
- clk  in  1  system clock.
- res  in  1  asynchronous active-low reset.
- en  in  1  level; allows leaving IDLE and starting new CH passes.
- ts_valid  in  1  timestamp valid.
- ts_data  in  TS_W  timestamp.
- ts_ready  out  1  mapper accepts ts_data this cycle.
- peak_ch  in  NB  coarse peak bin from the builder.
- peak_done  in  1  one-cycle pulse from the builder; peak_ch is valid in that cycle.
- wrEn  out  1  bin write strobe to the builder.
- addr  out  NB  bin address to the builder.
- mode  out  1  0 = CH pass, 1 = FH pass.
- frame_done  out  1  one-cycle pulse when an FH pass completes.
- drop_cnt  out  16  saturating count of FH out-of-window events.

Behaviour:
- Reset (async, res low): wrEn=0, addr=0, mode=0, frame_done=0, drop_cnt=0, evt_cnt=0, base=0, state IDLE. ts_ready=0 while in reset.
- States:
  - IDLE -> CH_RUN when en=1.
  - CH_RUN -> PEAK_WAIT when evt_cnt reaches FRAME_EVENTS.
  - PEAK_WAIT -> FH_RUN on peak_done.
  - FH_RUN -> CH_RUN if en=1, else IDLE, when evt_cnt reaches FRAME_EVENTS.
- Handshake: ts_ready = (state==CH_RUN || state==FH_RUN) && evt_cnt<FRAME_EVENTS, decoded combinationally. An event is accepted when ts_valid && ts_ready.
- CH mapping: addr = ts_data[TS_W-1:CH_SHIFT]. Every accepted event is emitted and increments evt_cnt.
- FH window:
  - On the peak_done cycle in PEAK_WAIT: base <= peak_ch << CH_SHIFT, mode <= 1, evt_cnt <= 0.
  - In window when ts_data[TS_W-1:CH_SHIFT] == base[TS_W-1:CH_SHIFT]. Then addr = (ts_data-base)>>FH_SHIFT, truncated to NB bits; the event is emitted and increments evt_cnt.
  - Out-of-window events are consumed with no wrEn. evt_cnt is unchanged; drop_cnt increments and saturates at 0xFFFF.
- Latency: wrEn/addr are registered one cycle after acceptance. wrEn is high for exactly one cycle per emitted event. addr holds its last value when wrEn=0.
- No backpressure from the builder; back-to-back emission at one per clock is allowed.
- Terminal count: the event that makes evt_cnt==FRAME_EVENTS is emitted normally. ts_ready drops in the next cycle. The state transition and evt_cnt clear happen on the following clock edge.
- FH completion: frame_done pulses for one cycle, coincident with the state change out of FH_RUN. mode returns to 0.
- peak_done outside PEAK_WAIT is ignored. en changes mid-pass are ignored until the pass ends. drop_cnt clears only on reset.
- Reset mid-pass aborts the pass immediately; no partial state survives.

Test Plan (NB=3, CH_SHIFT=6, FH_SHIFT=3, TS_W=9, FRAME_EVENTS=4):
1. Hold res low, drive ts_valid=1 -> wrEn=0, addr=0, mode=0, ts_ready=0, drop_cnt=0. Release res, en=1 -> ts_ready=1 next cycle.
2. CH: accept ts=453 -> one cycle later wrEn=1, addr=7. Accept ts=64 -> addr=1, back-to-back wrEn.
3. After 4 CH emits -> ts_ready=0, mode=0, pulses on peak_done ignored until PEAK_WAIT. In PEAK_WAIT, peak_done with peak_ch=3 -> mode=1, base=192, ts_ready=1.
4. FH: ts=205 -> wrEn, addr=1. ts=255 -> addr=7. ts=100 -> no wrEn, drop_cnt=1, evt_cnt unchanged.
5. Complete 4 in-window FH emits with en=1 -> frame_done one pulse, mode=0, CH_RUN resumes. Repeat with en=0 -> IDLE, ts_ready stays 0.
6. Assert res mid-FH after 2 emits -> wrEn=0 immediately, mode=0, drop_cnt=0, IDLE. A fresh CH pass then needs 4 full emits.
